// File: rtl/nn_pkg.sv
// Shared definitions for the binarized MNIST frame driver.
// Holds the frame geometry, the class width, the controller state encoding,
// the default threshold / timeout values and the pixel binarize helper.
package nn_pkg;

  localparam int NUM_PIXELS             = 784;
  localparam int PIXEL_W                = 8;
  localparam int CLASS_W                = 4;
  localparam int COUNT_W                = 10;
  localparam int THRESHOLD_DEFAULT      = 128;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    DRAIN  = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } nn_state_e;

  // A pixel at or above the threshold becomes a set feature bit.
  function automatic logic binarize(input logic [PIXEL_W-1:0] pix,
                                    input int unsigned        thr);
    return (32'(pix) >= thr) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/nn_frame_driver_if.sv
// Bus bundle for nn_frame_driver.
// Groups the pixel stream (pix_*), the classifier core link (nn_*) and the
// result port (res_*).
//   master : environment side (pixel source, core, result sink)
//   slave  : the frame driver itself
interface nn_frame_driver_if;
  import nn_pkg::*;

  logic                  pix_valid;
  logic [PIXEL_W-1:0]    pix_data;
  logic                  pix_last;
  logic                  pix_ready;
  logic                  nn_start;
  logic [NUM_PIXELS-1:0] nn_features;
  logic                  nn_done;
  logic [CLASS_W-1:0]    nn_prediction;
  logic                  res_valid;
  logic                  res_ready;
  logic [CLASS_W-1:0]    res_class;
  logic                  res_error;

  modport master (
    output pix_valid, pix_data, pix_last, nn_done, nn_prediction, res_ready,
    input  pix_ready, nn_start, nn_features, res_valid, res_class, res_error
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, nn_done, nn_prediction, res_ready,
    output pix_ready, nn_start, nn_features, res_valid, res_class, res_error
  );

endinterface

// File: rtl/nn_frame_driver_pixel_packer.sv
// pixel_packer: thresholds accepted pixels and packs them into the feature
// vector, pixel k landing in bit k.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      zero the count and the feature vector (frame retired)
//   load_en    a pixel is accepted this cycle; write its bit and advance
//   pix_data   pixel being accepted
//   features   packed feature vector (registered)
//   last_idx   the next accepted pixel is the last one of a full frame
module pixel_packer
  import nn_pkg::*;
#(
  parameter int unsigned THRESHOLD = THRESHOLD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic [PIXEL_W-1:0]    pix_data,
  output logic [NUM_PIXELS-1:0] features,
  output logic                  last_idx
);

  logic [NUM_PIXELS-1:0] features_r;
  logic [COUNT_W-1:0]    count_r;
  logic                  bit_s;

  assign bit_s    = binarize(pix_data, THRESHOLD);
  assign features = features_r;
  assign last_idx = (count_r == COUNT_W'(NUM_PIXELS - 1));

  // Pixel count and indexed feature-bit insert; clear wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      features_r <= '0;
      count_r    <= '0;
    end else if (clear) begin
      features_r <= '0;
      count_r    <= '0;
    end else if (load_en) begin
      features_r[count_r] <= bit_s;
      count_r             <= count_r + COUNT_W'(1);
    end else begin
      features_r <= features_r;
      count_r    <= count_r;
    end
  end

endmodule

// File: rtl/nn_frame_driver.sv
// nn_frame_driver: collects one frame of grayscale pixels, binarizes and
// packs them, starts the classifier core, waits for done (with a timeout)
// and returns the class on the result port. Short and long frames and a
// hung core are reported with res_error=1 and res_class=0.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       nn_frame_driver_if.slave: pixel stream in, core link,
//             result stream out
module nn_frame_driver
  import nn_pkg::*;
#(
  parameter int unsigned THRESHOLD      = THRESHOLD_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  nn_frame_driver_if.slave  bus
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  nn_state_e             state_r;
  nn_state_e             state_next_s;
  logic                  accept_s;
  logic                  pk_load_s;
  logic                  pk_clear_s;
  logic                  last_idx_s;
  logic [NUM_PIXELS-1:0] features_s;
  logic [TO_W-1:0]       to_cnt_r;
  logic                  to_clear_s;
  logic                  to_inc_s;
  logic                  timeout_s;
  logic                  res_load_s;
  logic                  res_err_s;
  logic [CLASS_W-1:0]    res_cls_s;
  logic                  pix_ready_r;
  logic                  nn_start_r;
  logic                  res_valid_r;
  logic [CLASS_W-1:0]    res_class_r;
  logic                  res_error_r;

  assign accept_s  = bus.pix_valid & pix_ready_r;
  assign timeout_s = (to_cnt_r == TO_LAST);

  pixel_packer #(
    .THRESHOLD (THRESHOLD)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pk_clear_s),
    .load_en  (pk_load_s),
    .pix_data (bus.pix_data),
    .features (features_s),
    .last_idx (last_idx_s)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    pk_load_s    = 1'b0;
    pk_clear_s   = 1'b0;
    to_clear_s   = 1'b0;
    to_inc_s     = 1'b0;
    res_load_s   = 1'b0;
    res_err_s    = 1'b0;
    res_cls_s    = '0;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          pk_load_s = 1'b1;
          if (bus.pix_last && last_idx_s) begin
            state_next_s = FIRE;
          end else if (bus.pix_last) begin
            // Frame ended early.
            state_next_s = RESULT;
            res_load_s   = 1'b1;
            res_err_s    = 1'b1;
          end else if (last_idx_s) begin
            // Full frame collected but no end marker: swallow the excess.
            state_next_s = DRAIN;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      DRAIN: begin
        if (accept_s && bus.pix_last) begin
          state_next_s = RESULT;
          res_load_s   = 1'b1;
          res_err_s    = 1'b1;
        end else begin
          state_next_s = DRAIN;
        end
      end
      FIRE: begin
        to_clear_s   = 1'b1;
        state_next_s = WAIT;
      end
      WAIT: begin
        to_inc_s = 1'b1;
        // done takes priority over a timeout landing in the same cycle.
        if (bus.nn_done) begin
          state_next_s = RESULT;
          res_load_s   = 1'b1;
          res_err_s    = 1'b0;
          res_cls_s    = bus.nn_prediction;
        end else if (timeout_s) begin
          state_next_s = RESULT;
          res_load_s   = 1'b1;
          res_err_s    = 1'b1;
          res_cls_s    = '0;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_next_s = LOAD;
          pk_clear_s   = 1'b1;
        end else begin
          state_next_s = RESULT;
        end
      end
      default: begin
        state_next_s = LOAD;
      end
    endcase
  end

  // Core wait timeout counter, cleared while firing.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (to_clear_s) begin
      to_cnt_r <= '0;
    end else if (to_inc_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Registered pixel-ready and start pulse, both derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_ready_r <= 1'b1;
      nn_start_r  <= 1'b0;
    end else begin
      pix_ready_r <= (state_next_s == LOAD) || (state_next_s == DRAIN);
      nn_start_r  <= (state_next_s == FIRE);
    end
  end

  // Result registers: loaded on entry to RESULT, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_class_r <= '0;
      res_error_r <= 1'b0;
    end else if (res_load_s) begin
      res_valid_r <= 1'b1;
      res_class_r <= res_cls_s;
      res_error_r <= res_err_s;
    end else if (pk_clear_s) begin
      res_valid_r <= 1'b0;
      res_class_r <= res_class_r;
      res_error_r <= res_error_r;
    end else begin
      res_valid_r <= res_valid_r;
      res_class_r <= res_class_r;
      res_error_r <= res_error_r;
    end
  end

  assign bus.pix_ready   = pix_ready_r;
  assign bus.nn_start    = nn_start_r;
  assign bus.nn_features = features_s;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_class   = res_class_r;
  assign bus.res_error   = res_error_r;

endmodule
